sram_1r1w_pipe: RTL



---
 rtl/sram_pkg.sv | 42 ++++
 rtl/sram_1r1w_pipe_if.sv | 30 +++
 rtl/sram_clear_seq.sv | 47 ++++
 rtl/sram_1r1w_pipe.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the 1R1W SRAM model: clear-sequencer state codes,
// legal read-latency values and the granule merge / parity helpers used by
// both the write path and the collision bypass.
// Helpers operate on MAX_DATA_W-wide vectors; callers zero-extend their
// operands and truncate the result back to their own word width.
package sram_pkg;

  typedef logic [0:0] sram_state_t;
  localparam sram_state_t S_INIT = 1'b0;
  localparam sram_state_t S_RUN  = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  localparam int MAX_DATA_W = 1024;

  // Per-bit select: granule g of the result comes from new_d when mask[g] is set.
  function automatic logic [MAX_DATA_W-1:0] merge_granules(
    input logic [MAX_DATA_W-1:0] old_d,
    input logic [MAX_DATA_W-1:0] new_d,
    input logic [MAX_DATA_W-1:0] mask,
    input int                    gran_w
  );
    logic [MAX_DATA_W-1:0] res;
    for (int i = 0; i < MAX_DATA_W; i++)
      res[i] = mask[i / gran_w] ? new_d[i] : old_d[i];
    return res;
  endfunction

  // Bit g of the result is the XOR of all bits in granule g (even parity).
  function automatic logic [MAX_DATA_W-1:0] granule_parity(
    input logic [MAX_DATA_W-1:0] d,
    input int                    gran_w
  );
    logic [MAX_DATA_W-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_DATA_W; i++)
      p[i / gran_w] = p[i / gran_w] ^ d[i];
    return p;
  endfunction

endpackage

// File: rtl/sram_1r1w_pipe_if.sv
// Request/response bundle of sram_1r1w_pipe.
//   master: drives init_req, W_en/W_addr/W_data/W_mask, R_en/R_addr
//   slave : drives init_busy, R_data, R_valid, par_err
interface sram_1r1w_pipe_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16
);
  logic              init_req;
  logic              init_busy;
  logic              W_en;
  logic [ADDR_W-1:0] W_addr;
  logic [DATA_W-1:0] W_data;
  logic [MASK_W-1:0] W_mask;
  logic              R_en;
  logic [ADDR_W-1:0] R_addr;
  logic [DATA_W-1:0] R_data;
  logic              R_valid;
  logic              par_err;

  modport master (
    output init_req, W_en, W_addr, W_data, W_mask, R_en, R_addr,
    input  init_busy, R_data, R_valid, par_err
  );

  modport slave (
    input  init_req, W_en, W_addr, W_data, W_mask, R_en, R_addr,
    output init_busy, R_data, R_valid, par_err
  );
endinterface

// File: rtl/sram_clear_seq.sv
// Clear sequencer: walks every entry once after reset or init_req and
// reports the entry to zero on clr_en/clr_addr.
// Ports: clock, reset (async, active-high), init_req in;
//        clr_en, clr_addr, init_busy out.
//
// state  | meaning
// S_INIT | sweeping, one entry per cycle; array closed to users
// S_RUN  | normal operation; init_req restarts the sweep
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_req,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  sram_state_t       state_q;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else if (state_q == S_INIT) begin
      if (cnt_q == LAST) begin
        state_q <= S_RUN;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (init_req) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end
  end

  assign init_busy = (state_q == S_INIT);
  assign clr_en    = init_busy;
  assign clr_addr  = cnt_q;
endmodule

// File: rtl/sram_1r1w_pipe.sv
// Behavioural 1-read/1-write SRAM with clear-on-reset sweep, write-to-read
// collision forwarding, read-valid pipeline and held read data.
// Ports: clock, reset (async, active-high); bus (sram_1r1w_pipe_if.slave).
// Optional: define SRAM_1R1W_PIPE_PARITY_EN to store one even-parity bit per
// granule and flag mismatches on par_err; otherwise par_err is tied low.
module sram_1r1w_pipe
  import sram_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128,
  parameter int GRAN_W = 8,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input logic clock,
  input logic reset,
  sram_1r1w_pipe_if.slave bus
);
  localparam int MASK_W = DATA_W / GRAN_W;
  localparam int IDX_W  = $clog2(DEPTH);

  logic             clr_en;
  logic [IDX_W-1:0] clr_idx;
  logic             init_busy;

  sram_clear_seq #(.DEPTH(DEPTH), .ADDR_W(IDX_W)) u_clear (
    .clock     (clock),
    .reset     (reset),
    .init_req  (bus.init_req),
    .clr_en    (clr_en),
    .clr_addr  (clr_idx),
    .init_busy (init_busy)
  );
  assign bus.init_busy = init_busy;

  // Range compare is one bit wider so DEPTH == 2**ADDR_W does not wrap to 0.
  logic             w_in_range, r_in_range, wr_ok, rd_acc, collide;
  logic [IDX_W-1:0] w_idx, r_idx;

  assign w_in_range = {1'b0, bus.W_addr} < (ADDR_W + 1)'(DEPTH);
  assign r_in_range = {1'b0, bus.R_addr} < (ADDR_W + 1)'(DEPTH);
  assign wr_ok      = bus.W_en && !init_busy && w_in_range;
  assign rd_acc     = bus.R_en && !init_busy;
  assign w_idx      = bus.W_addr[IDX_W-1:0];
  assign r_idx      = bus.R_addr[IDX_W-1:0];
  assign collide    = (BYPASS != 0) && wr_ok && (bus.W_addr == bus.R_addr);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] w_merged, r_raw, r_word;

  assign w_merged = DATA_W'(merge_granules(MAX_DATA_W'(mem[w_idx]),
                                           MAX_DATA_W'(bus.W_data),
                                           MAX_DATA_W'(bus.W_mask), GRAN_W));

  // The clear sweep owns the write port while busy; user writes are blocked then anyway.
  always_ff @(posedge clock) begin
    if (clr_en)
      mem[clr_idx] <= '0;
    else if (wr_ok)
      mem[w_idx] <= w_merged;
  end

  assign r_raw = mem[r_idx];

  always_comb begin
    r_word = '0;
    if (r_in_range) begin
      if (collide)
        r_word = DATA_W'(merge_granules(MAX_DATA_W'(r_raw), MAX_DATA_W'(bus.W_data),
                                        MAX_DATA_W'(bus.W_mask), GRAN_W));
      else
        r_word = r_raw;
    end
  end

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc)
        s1_data <= r_word;
    end
  end

  if (RD_LAT == RD_LAT_MAX) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= s1_valid;
        if (s1_valid)
          d2 <= s1_data;
      end
    end
    assign bus.R_valid = v2;
    assign bus.R_data  = d2;
  end else begin : g_lat1
    assign bus.R_valid = s1_valid;
    assign bus.R_data  = s1_data;
  end

`ifdef SRAM_1R1W_PIPE_PARITY_EN
  logic [MASK_W-1:0] par_mem [DEPTH];
  logic [MASK_W-1:0] w_par_new, r_par_raw, r_par, r_par_calc;
  logic              r_err, s1_perr;

  assign w_par_new = MASK_W'(granule_parity(MAX_DATA_W'(bus.W_data), GRAN_W));

  always_ff @(posedge clock) begin
    if (clr_en)
      par_mem[clr_idx] <= '0;
    else if (wr_ok)
      par_mem[w_idx] <= (bus.W_mask & w_par_new) | (~bus.W_mask & par_mem[w_idx]);
  end

  // Forwarded granules carry freshly computed parity, so they never flag.
  assign r_par_raw  = par_mem[r_idx];
  assign r_par      = collide ? ((bus.W_mask & w_par_new) | (~bus.W_mask & r_par_raw)) : r_par_raw;
  assign r_par_calc = MASK_W'(granule_parity(MAX_DATA_W'(r_word), GRAN_W));
  assign r_err      = r_in_range && ((r_par_calc ^ r_par) != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      s1_perr <= 1'b0;
    else
      s1_perr <= rd_acc && r_err;
  end

  if (RD_LAT == RD_LAT_MAX) begin : g_perr2
    logic perr2;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        perr2 <= 1'b0;
      else
        perr2 <= s1_perr;
    end
    assign bus.par_err = perr2;
  end else begin : g_perr1
    assign bus.par_err = s1_perr;
  end
`else
  assign bus.par_err = 1'b0;
`endif
endmodule
